// File: rtl/dense_int_back_pkg.sv
// Shared definitions for the final dense stage of the int8 classifier.
//   clogb2   : bits needed to hold a value (minimum 1), used for counter and index widths
//   sat_int8 : clamps a signed 32-bit sum into the int8 range [-128, 127]
//   state_t  : frame FSM encoding (ACC -> DRAIN -> OUT -> ACC)
package dense_int_back_pkg;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    localparam int SAT_IN_W = 32;

    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic signed [7:0] sat_int8(input logic signed [SAT_IN_W-1:0] x);
        if (x > 32'sd127) begin
            return 8'sh7f;
        end else if (x < -32'sd128) begin
            return 8'sh80;
        end
        return x[7:0];
    endfunction

endpackage

// File: rtl/dense_int_back_rom.sv
// Synchronous read-only memory with one cycle of read latency.
//   clk  : clock
//   addr : word address, sampled on the rising edge
//   data : registered word mem[addr]
// FILE names the image the contents are built from; the array has no write
// port and is populated by the image load flow.
module dense_int_back_rom
    import dense_int_back_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter int    DEPTH = 16,
    parameter string FILE  = ""
) (
    input  logic                        clk,
    input  logic [clogb2(DEPTH-1)-1:0]  addr,
    output logic [WIDTH-1:0]            data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays and their read register take no reset; clearing a
    // RAM/ROM array on reset would turn it into a flop bank.
    always_ff @(posedge clk) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/dense_int_back.sv
// Final fully-connected stage of the int8 classifier.
// Accumulates B serial int8 activations against an N-wide kernel row per
// input, adds a per-class bias, saturates to int8, streams the N logits out
// one per cycle and then reports the argmax class.
//   clk           : clock
//   rstn          : synchronous active-low reset
//   valid_i       : data_i carries an activation this cycle (ignored while busy_o)
//   data_i        : signed int8 activation
//   busy_o        : high while draining the last MAC and emitting logits
//   data_o        : saturated signed logit
//   valid_o       : data_o valid, one cycle per class
//   last_o        : marks the logit of class N-1
//   class_o       : argmax class index (ties resolve to the lower index)
//   class_valid_o : one-cycle pulse qualifying class_o
module dense_int_back
    import dense_int_back_pkg::*;
#(
    parameter string BIASFILE   = "mini_dense1_bias.txt",
    parameter string KERNELFILE = "mini_dense1_kernel.txt",
    parameter int    B          = 64,
    parameter int    N          = 10,
    parameter int    DATA_WIDTH = 8,
    parameter int    ACC_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic                        busy_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    output logic                        last_o,
    output logic [clogb2(N-1)-1:0]      class_o,
    output logic                        class_valid_o
);

    localparam int IN_W  = clogb2(B-1);
    localparam int CLS_W = clogb2(N-1);

    state_t                          state_q, state_d;
    logic [IN_W-1:0]                 in_cnt_q;
    logic [CLS_W-1:0]                out_cnt_q;
    logic signed [DATA_WIDTH-1:0]    data_d;
    logic                            valid_d;
    logic                            accept;
    logic                            out_last;
    logic [CLS_W-1:0]                bias_addr;

    logic [N*DATA_WIDTH-1:0]         kernel_row;
    logic signed [ACC_WIDTH-1:0]     bias_q;
    logic signed [2*DATA_WIDTH-1:0]  prod [N];
    logic signed [ACC_WIDTH-1:0]     acc  [N];
    logic signed [ACC_WIDTH-1:0]     sum;
    logic signed [7:0]               sat;

    logic signed [7:0]               best_q;
    logic [CLS_W-1:0]                best_idx_q;
    logic [CLS_W-1:0]                class_idx_q;
    logic                            class_pend_q;

    // Kernel row for the input being captured; it lines up with data_d one cycle later.
    dense_int_back_rom #(
        .WIDTH (N*DATA_WIDTH),
        .DEPTH (B),
        .FILE  (KERNELFILE)
    ) u_kernel_rom (
        .clk  (clk),
        .addr (in_cnt_q),
        .data (kernel_row)
    );

    // Bias is fetched one class ahead so bias_q matches out_cnt_q in every OUT cycle.
    dense_int_back_rom #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (N),
        .FILE  (BIASFILE)
    ) u_bias_rom (
        .clk  (clk),
        .addr (bias_addr),
        .data (bias_q)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        out_last  = 1'b0;
        bias_addr = '0;
        case (state_q)
            ST_ACC: begin
                if (valid_i) begin
                    accept = 1'b1;
                    if (in_cnt_q == IN_W'(B-1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_cnt_q == CLS_W'(N-1)) begin
                    out_last = 1'b1;
                    state_d  = ST_ACC;
                end else begin
                    bias_addr = out_cnt_q + CLS_W'(1);
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_comb begin
        for (int n = 0; n < N; n++) begin
            prod[n] = data_d * $signed(kernel_row[n*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign sum = acc[out_cnt_q] + bias_q;
    assign sat = sat_int8(SAT_IN_W'(sum));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int n = 0; n < N; n++) begin
                acc[n] <= '0;
            end
        end else if (out_last) begin
            for (int n = 0; n < N; n++) begin
                acc[n] <= '0;
            end
        end else if (valid_d) begin
            for (int n = 0; n < N; n++) begin
                acc[n] <= acc[n] + ACC_WIDTH'(prod[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_ACC;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            data_d        <= '0;
            valid_d       <= 1'b0;
            busy_o        <= 1'b0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            last_o        <= 1'b0;
            class_o       <= '0;
            class_valid_o <= 1'b0;
            best_q        <= 8'sh80;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != ST_ACC);
            valid_d <= accept;

            if (accept) begin
                data_d   <= data_i;
                in_cnt_q <= (in_cnt_q == IN_W'(B-1)) ? '0 : in_cnt_q + IN_W'(1);
            end

            valid_o      <= (state_q == ST_OUT);
            last_o       <= out_last;
            class_pend_q <= out_last;

            if (state_q == ST_OUT) begin
                data_o    <= DATA_WIDTH'(sat);
                out_cnt_q <= out_last ? '0 : out_cnt_q + CLS_W'(1);
                if (out_last) begin
                    // The final class still competes before the tracker restarts.
                    class_idx_q <= (sat > best_q) ? out_cnt_q : best_idx_q;
                    best_q      <= 8'sh80;
                    best_idx_q  <= '0;
                end else if (sat > best_q) begin
                    best_q     <= sat;
                    best_idx_q <= out_cnt_q;
                end
            end else begin
                out_cnt_q <= '0;
            end

            class_valid_o <= class_pend_q;
            if (class_pend_q) begin
                class_o <= class_idx_q;
            end
        end
    end

endmodule

// File: doc/dense_int_back.md
Name: dense_int_back

Overview:
- Final fully-connected stage of the int8 classifier.
- Consumes the serial int8 stream of B activations from the preceding dense front stage, one value per valid_i pulse.
- Multiplies each value against an N-wide ROM kernel row and accumulates N signed sums.
- Adds per-class bias, saturates to int8, emits N logits serially, then emits the argmax class index.

Parameters:
- BIASFILE, "mini_dense1_bias.txt", bias ROM init file: N entries, 32-bit signed.
- KERNELFILE, "mini_dense1_kernel.txt", kernel ROM init file: B entries, each N*DATA_WIDTH bits; class n in bits [n*8+:8].
- B, 64, inputs per frame (upstream output count).
- N, 10, output classes.
- DATA_WIDTH, 8, activation and weight width.
- ACC_WIDTH, 32, accumulator width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- valid_i  in  1  data_i valid this cycle.
- data_i  in  DATA_WIDTH  signed int8 activation.
- busy_o  out  1  high in DRAIN/OUT; valid_i ignored while high.
- data_o  out  DATA_WIDTH  saturated signed logit.
- valid_o  out  1  data_o valid, one cycle per class.
- last_o  out  1  with valid_o on class N-1.
- class_o  out  clogb2(N-1)  argmax index.
- class_valid_o  out  1  one-cycle pulse, class_o valid.

Behaviour:
- Reset (rstn=0 at a clk edge), from any state including mid-frame:
  - state=ACC, in_cnt=0, out_cnt=0, all N accumulators=0.
  - data_d, valid_d, data_o, valid_o, last_o, class_o, class_valid_o, busy_o all 0.
  - Best-so-far value = -128, best index = 0.
- Kernel ROM: synchronous, 1-cycle read latency, address = in_cnt.
- Bias ROM: synchronous, 1-cycle read latency.
  - Address = out_cnt+1 in OUT, otherwise 0.
  - mem_b therefore holds bias[out_cnt] during every OUT cycle.
- ACC:
  - valid_i=1 → capture data_d=data_i, valid_d=1; increment in_cnt.
  - When in_cnt==B-1 and valid_i=1: in_cnt→0, state→DRAIN.
  - Gaps between valid_i pulses are allowed; back-to-back pulses are allowed.
- MAC (any state, next cycle after capture):
  - If valid_d=1: acc[n] += sext(data_d * kernel[n]) for all n in parallel.
  - Product is 16-bit signed, sign-extended to ACC_WIDTH; no overflow check on acc.
- DRAIN: one cycle; final MAC completes; busy_o=1; state→OUT, out_cnt=0.
- OUT: one class per cycle.
  - sum = acc[out_cnt] + mem_b (signed 32).
  - sat = 127 if sum>127; -128 if sum<-128; else sum[7:0].
  - Registered: data_o=sat, valid_o=1, last_o=(out_cnt==N-1).
  - Argmax: if sat > best (strict), best=sat and index=out_cnt. Ties keep the lower index.
  - At out_cnt==N-1: clear accs, reset best, state→ACC, out_cnt→0.
  - Next cycle: class_o=final index, class_valid_o=1.
- Timing, with the last input accepted at cycle T:
  - State DRAIN at T+1; OUT from T+2 to T+N+1.
  - valid_o high T+3..T+N+2; last_o at T+N+2; class_valid_o at T+N+3.
- busy_o: registered, high in DRAIN and OUT. valid_i asserted while busy is dropped with no effect on state.
- A new frame may start at T+N+2, while the final logit/class outputs are still draining.
- All single-cycle pulse outputs deassert the following cycle.

Decomposition:
- Shared package holds:
  - clogb2 function.
  - int8 saturate function (ACC_WIDTH signed in, int8 out, ±127/-128 limits).
  - FSM state encoding: ACC, DRAIN, OUT.
- The existing rom module is instantiated twice, for bias and kernel.
- No further sub-module; accumulator array, FSM and argmax stay inline.

Test Plan:
- Kernel all 1, bias 0, 64 inputs of 1 back-to-back → 10 valid_o with data_o=64; last_o on 10th; class_o=0.
- Kernel all 127, inputs 127 → all data_o=127. Negate the kernel → all data_o=-128. Bias -2^20 with zero inputs → -128.
- Inputs all 0, bias[3]=50, others 0 → data_o=0 except class 3 =50; class_o=3. Latency exactly T+3 to first valid_o.
- Tie: bias[2]=bias[7]=5, rest 0, inputs 0 → class_o=2.
- Inputs with random 0-3 cycle gaps versus back-to-back, same data → identical outputs. valid_i pulses during busy_o → dropped; results unchanged.
- rstn low after 30 inputs, then a full frame of 1s with unit kernel → data_o=64 for every class (no residue); all outputs 0 during reset.
